// File: rtl/ahb_slave_mux_dfslv_if.sv
// Bundle of decoder, slave-return and master-facing signals around the AHB-Lite data-phase mux.
// The mux owns the slave modport. The master modport is the view from the surrounding bus fabric.
interface ahb_slave_mux_dfslv_if #(
  parameter int NUM_SLAVES = 10,
  parameter int DW         = 32
);
  logic [3:0]             MUX_SEL;
  logic                   HSEL_NOMAP;
  logic [1:0]             HTRANS;
  logic [NUM_SLAVES*DW-1:0] HRDATA_S;
  logic [NUM_SLAVES-1:0]  HREADYOUT_S;
  logic [NUM_SLAVES-1:0]  HRESP_S;
  logic [DW-1:0]          HRDATA;
  logic                   HREADY;
  logic                   HRESP;

  modport slave (
    input  MUX_SEL, HSEL_NOMAP, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
    output HRDATA, HREADY, HRESP
  );

  modport master (
    output MUX_SEL, HSEL_NOMAP, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
    input  HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_slave_mux_dfslv.sv
// AHB-Lite data-phase response mux with an embedded default slave.
// The default slave answers unmapped NONSEQ/SEQ transfers with a two-cycle ERROR.
module ahb_slave_mux_dfslv #(
  parameter int NUM_SLAVES = 10,
  parameter int DW         = 32
) (
  input logic                   HCLK,
  input logic                   HRESETn,
  ahb_slave_mux_dfslv_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ERR1 = 2'd1;
  localparam logic [1:0] ST_ERR2 = 2'd2;

  logic [3:0]    data_sel;
  logic [1:0]    dfs_state;
  logic [1:0]    dfs_next;
  logic          dfs_ready;
  logic          dfs_resp;
  logic          nomap_req;
  logic [DW-1:0] rdata_mux;
  logic          ready_mux;
  logic          resp_mux;

  // The select is captured only on a completed address phase, so it holds through wait states.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      data_sel <= 4'hF;
    end else if (ready_mux) begin
      data_sel <= bus.MUX_SEL;
    end
  end

  assign nomap_req = bus.HSEL_NOMAP & ready_mux & bus.HTRANS[1];

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dfs_state <= ST_IDLE;
    end else begin
      dfs_state <= dfs_next;
    end
  end

  always_comb begin
    dfs_next  = dfs_state;
    dfs_ready = 1'b1;
    dfs_resp  = 1'b0;
    case (dfs_state)
      ST_IDLE: begin
        if (nomap_req) dfs_next = ST_ERR1;
      end
      ST_ERR1: begin
        dfs_ready = 1'b0;
        dfs_resp  = 1'b1;
        dfs_next  = ST_ERR2;
      end
      ST_ERR2: begin
        dfs_resp = 1'b1;
        dfs_next = nomap_req ? ST_ERR1 : ST_IDLE;
      end
      default: begin
        dfs_next = ST_IDLE;
      end
    endcase
  end

  // Any select outside the mapped range, including 4'hF, falls through to the default slave.
  always_comb begin
    rdata_mux = '0;
    ready_mux = dfs_ready;
    resp_mux  = dfs_resp;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (data_sel == 4'(i)) begin
        rdata_mux = bus.HRDATA_S[i*DW +: DW];
        ready_mux = bus.HREADYOUT_S[i];
        resp_mux  = bus.HRESP_S[i];
      end
    end
  end

  assign bus.HRDATA = rdata_mux;
  assign bus.HREADY = ready_mux;
  assign bus.HRESP  = resp_mux;

endmodule

// File: tb/tb_ahb_slave_mux_dfslv.sv
// Self-checking bench for ahb_slave_mux_dfslv: directed scenarios followed by randomized traffic,
// all compared against a transaction-level model of the select register and error counter.
module tb_ahb_slave_mux_dfslv;

  localparam int NS = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ahb_slave_mux_dfslv_if #(.NUM_SLAVES(NS), .DW(DW)) bus ();

  ahb_slave_mux_dfslv #(.NUM_SLAVES(NS), .DW(DW)) dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus)
  );

  logic [DW-1:0] s_data [NS];
  logic [NS-1:0] s_ready;
  logic [NS-1:0] s_resp;

  always_comb begin
    for (int i = 0; i < NS; i++) bus.HRDATA_S[i*DW +: DW] = s_data[i];
  end
  assign bus.HREADYOUT_S = s_ready;
  assign bus.HRESP_S     = s_resp;

  // Model: which slave owns the data phase, and how many error-response cycles remain.
  int            m_sel;
  int            m_err_left;
  logic [DW-1:0] exp_data;
  logic          exp_ready;
  logic          exp_resp;

  int check_count = 0;
  int pass_count  = 0;
  int fail_count  = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_outputs();
    if (m_sel < NS) begin
      exp_data  = s_data[m_sel];
      exp_ready = s_ready[m_sel];
      exp_resp  = s_resp[m_sel];
    end else begin
      exp_data  = '0;
      exp_ready = (m_err_left != 2);
      exp_resp  = (m_err_left != 0);
    end
  endfunction

  task automatic apply_stimulus(input logic rstn, input logic [3:0] sel, input logic nomap,
                                input logic [1:0] trans);
    @(negedge clk);
    rst_n          = rstn;
    bus.MUX_SEL    = sel;
    bus.HSEL_NOMAP = nomap;
    bus.HTRANS     = trans;
  endtask

  task automatic set_slave(input int idx, input logic [DW-1:0] data, input logic rdy, input logic rsp);
    s_data[idx]  = data;
    s_ready[idx] = rdy;
    s_resp[idx]  = rsp;
  endtask

  task automatic check_output(input string tag);
    #1;
    model_outputs();
    check({tag, ".hrdata"}, bus.HRDATA, exp_data);
    check({tag, ".hready"}, {31'd0, bus.HREADY}, {31'd0, exp_ready});
    check({tag, ".hresp"},  {31'd0, bus.HRESP},  {31'd0, exp_resp});
  endtask

  task automatic check_const(input string tag, input logic rdy, input logic rsp);
    check({tag, ".hready_c"}, {31'd0, bus.HREADY}, {31'd0, rdy});
    check({tag, ".hresp_c"},  {31'd0, bus.HRESP},  {31'd0, rsp});
  endtask

  // Advance the model across the rising edge using the inputs held stable through it.
  task automatic commit_cycle();
    logic req;
    #1;
    model_outputs();
    req = bus.HSEL_NOMAP && exp_ready && bus.HTRANS[1];
    @(posedge clk);
    if (!rst_n) begin
      m_sel      = 15;
      m_err_left = 0;
    end else begin
      if (exp_ready) m_sel = int'(bus.MUX_SEL);
      if (m_err_left == 2) m_err_left = 1;
      else m_err_left = req ? 2 : 0;
    end
  endtask

  initial begin
    int slot;
    m_sel      = 15;
    m_err_left = 0;
    bus.MUX_SEL = 4'hF; bus.HSEL_NOMAP = 1'b0; bus.HTRANS = 2'b00;
    for (int i = 0; i < NS; i++) set_slave(i, $urandom, 1'($urandom), 1'($urandom));

    // Reset with slaves driving junk
    apply_stimulus(1'b0, 4'h3, 1'b0, 2'b10);
    commit_cycle();
    apply_stimulus(1'b0, 4'h3, 1'b0, 2'b10);
    check_output("reset");
    check_const("reset", 1'b1, 1'b0);
    check("reset.hrdata_c", bus.HRDATA, 32'h0);
    commit_cycle();

    // Simple read from slave 2
    apply_stimulus(1'b1, 4'h2, 1'b0, 2'b10);
    check_output("s2_addr");
    commit_cycle();
    apply_stimulus(1'b1, 4'h0, 1'b0, 2'b00);
    set_slave(2, 32'hDEADBEEF, 1'b1, 1'b0);
    check_output("s2_data");
    check("s2_data.hrdata_c", bus.HRDATA, 32'hDEADBEEF);
    check_const("s2_data", 1'b1, 1'b0);
    commit_cycle();

    // Slave 3 inserts two wait states while the next address targets slave 5
    set_slave(0, 32'h0000_0000, 1'b1, 1'b0);
    apply_stimulus(1'b1, 4'h3, 1'b0, 2'b10);
    check_output("s3_addr");
    commit_cycle();
    set_slave(5, 32'h5555_AAAA, 1'b1, 1'b0);
    for (int w = 0; w < 2; w++) begin
      apply_stimulus(1'b1, 4'h5, 1'b0, 2'b10);
      set_slave(3, 32'h3333_0000 + 32'(w), 1'b0, 1'b0);
      check_output("s3_wait");
      check("s3_wait.hrdata_c", bus.HRDATA, 32'h3333_0000 + 32'(w));
      commit_cycle();
    end
    apply_stimulus(1'b1, 4'h5, 1'b0, 2'b10);
    set_slave(3, 32'h3333_00FF, 1'b1, 1'b0);
    check_output("s3_done");
    check("s3_done.hrdata_c", bus.HRDATA, 32'h3333_00FF);
    commit_cycle();
    apply_stimulus(1'b1, 4'h0, 1'b0, 2'b00);
    check_output("s5_data");
    check("s5_data.hrdata_c", bus.HRDATA, 32'h5555_AAAA);
    commit_cycle();

    // Single unmapped NONSEQ
    apply_stimulus(1'b1, 4'hF, 1'b1, 2'b10);
    check_output("nomap_addr");
    commit_cycle();
    apply_stimulus(1'b1, 4'h0, 1'b0, 2'b00);
    check_output("nomap_err1");
    check_const("nomap_err1", 1'b0, 1'b1);
    commit_cycle();
    apply_stimulus(1'b1, 4'h0, 1'b0, 2'b00);
    check_output("nomap_err2");
    check_const("nomap_err2", 1'b1, 1'b1);
    commit_cycle();
    apply_stimulus(1'b1, 4'h0, 1'b0, 2'b00);
    check_output("nomap_end");
    check_const("nomap_end", 1'b1, 1'b0);
    commit_cycle();

    // Back-to-back unmapped NONSEQ re-issued in the second error cycle
    apply_stimulus(1'b1, 4'hF, 1'b1, 2'b10);
    commit_cycle();
    apply_stimulus(1'b1, 4'hF, 1'b1, 2'b10);
    check_output("b2b_err1a");
    check_const("b2b_err1a", 1'b0, 1'b1);
    commit_cycle();
    apply_stimulus(1'b1, 4'hF, 1'b1, 2'b10);
    check_output("b2b_err2a");
    check_const("b2b_err2a", 1'b1, 1'b1);
    commit_cycle();
    apply_stimulus(1'b1, 4'h0, 1'b0, 2'b00);
    check_output("b2b_err1b");
    check_const("b2b_err1b", 1'b0, 1'b1);
    commit_cycle();
    apply_stimulus(1'b1, 4'h0, 1'b0, 2'b00);
    check_output("b2b_err2b");
    check_const("b2b_err2b", 1'b1, 1'b1);
    commit_cycle();
    apply_stimulus(1'b1, 4'hF, 1'b1, 2'b00);
    check_output("b2b_end");
    check_const("b2b_end", 1'b1, 1'b0);
    commit_cycle();

    // IDLE to unmapped space, then reset during the first error cycle
    apply_stimulus(1'b1, 4'hF, 1'b1, 2'b10);
    check_output("idle_nomap");
    check_const("idle_nomap", 1'b1, 1'b0);
    commit_cycle();
    apply_stimulus(1'b0, 4'hF, 1'b1, 2'b00);
    check_output("rst_err1");
    check_const("rst_err1", 1'b0, 1'b1);
    commit_cycle();
    apply_stimulus(1'b1, 4'hF, 1'b1, 2'b00);
    check_output("rst_after");
    check_const("rst_after", 1'b1, 1'b0);
    commit_cycle();

    // Randomized traffic that respects the decoder contract
    for (int n = 0; n < 400; n++) begin
      slot = $urandom_range(0, NS);
      if (slot == NS)
        apply_stimulus(($urandom_range(0, 40) != 0), 4'hF, 1'b1, 2'($urandom));
      else
        apply_stimulus(($urandom_range(0, 40) != 0), 4'(slot), 1'b0, 2'($urandom));
      for (int i = 0; i < NS; i++)
        set_slave(i, $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
      check_output("random");
      commit_cycle();
    end

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
